// File: rtl/alu_muldiv_if.sv
// Start/valid handshake bundle between the execute stage and the iterative mul/div unit.
// The core drives the request side (master); the unit answers on the result side (slave).
interface alu_muldiv_if #(parameter int DWIDTH = 32);
    logic              MD_Start;
    logic              MD_Flush;
    logic [2:0]        MD_OP;
    logic [DWIDTH-1:0] MD_In_A;
    logic [DWIDTH-1:0] MD_In_B;
    logic              MD_Ready;
    logic              MD_Busy;
    logic              MD_Valid;
    logic [DWIDTH-1:0] MD_Out;
    logic              MD_Zero_Flag;

    modport master (
        output MD_Start, MD_Flush, MD_OP, MD_In_A, MD_In_B,
        input  MD_Ready, MD_Busy, MD_Valid, MD_Out, MD_Zero_Flag
    );

    modport slave (
        input  MD_Start, MD_Flush, MD_OP, MD_In_A, MD_In_B,
        output MD_Ready, MD_Busy, MD_Valid, MD_Out, MD_Zero_Flag
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: unsigned shift-add / restoring-divide core on operand
// magnitudes, one bit per cycle, with sign fix-up and special cases applied on entry to DONE.
module alu_muldiv #(
    parameter int DWIDTH = 32
) (
    input  logic         Clk,
    input  logic         Rst_N,
    alu_muldiv_if.slave  md
);
    localparam int CW = $clog2(DWIDTH + 1);
    localparam logic [DWIDTH-1:0] MIN_VAL = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q;
    logic [2:0]          op_q;
    logic [2*DWIDTH-1:0] acc_q;
    logic [DWIDTH-1:0]   opnd_q;
    logic [DWIDTH-1:0]   aRaw_q;
    logic                signA_q;
    logic                signB_q;
    logic                ovf_q;
    logic [CW-1:0]       cnt_q;
    logic                ready_q;
    logic                busy_q;
    logic                valid_q;
    logic [DWIDTH-1:0]   out_q;
    logic                zero_q;

    logic                aSigned;
    logic                bSigned;
    logic                inSignA;
    logic                inSignB;
    logic [DWIDTH-1:0]   magA;
    logic [DWIDTH-1:0]   magB;
    logic [2*DWIDTH-1:0] accLoad_d;
    logic [DWIDTH-1:0]   opndLoad_d;
    logic                ovfLoad_d;

    // Operand decode at acceptance: magnitudes plus the signs needed for the final fix-up.
    always_comb begin
        aSigned    = 1'b0;
        bSigned    = 1'b0;
        case (md.MD_OP)
            3'b001, 3'b100, 3'b110: begin aSigned = 1'b1; bSigned = 1'b1; end
            3'b010:                 aSigned = 1'b1;
            default:                ;
        endcase
        inSignA    = aSigned & md.MD_In_A[DWIDTH-1];
        inSignB    = bSigned & md.MD_In_B[DWIDTH-1];
        magA       = inSignA ? -md.MD_In_A : md.MD_In_A;
        magB       = inSignB ? -md.MD_In_B : md.MD_In_B;
        accLoad_d  = md.MD_OP[2] ? {{DWIDTH{1'b0}}, magA} : {{DWIDTH{1'b0}}, magB};
        opndLoad_d = md.MD_OP[2] ? magB : magA;
        ovfLoad_d  = md.MD_OP[2] && !md.MD_OP[0] &&
                     (md.MD_In_A == MIN_VAL) && (md.MD_In_B == {DWIDTH{1'b1}});
    end

    logic [DWIDTH:0]     mulSum;
    logic [DWIDTH:0]     remSh;
    logic [DWIDTH:0]     remDiff;
    logic                qBit;
    logic [DWIDTH-1:0]   remNew;
    logic [2*DWIDTH-1:0] accStep_d;
    logic [2*DWIDTH-1:0] prodAdj;
    logic [DWIDTH-1:0]   quot;
    logic [DWIDTH-1:0]   rem;
    logic                bZero;
    logic [DWIDTH-1:0]   result_d;

    // acc_q holds {partial, multiplier/quotient}; the low half shifts out as the high half builds.
    always_comb begin
        mulSum    = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(DWIDTH+1){1'b0}});
        remSh     = {acc_q[2*DWIDTH-1:DWIDTH], acc_q[DWIDTH-1]};
        remDiff   = remSh - {1'b0, opnd_q};
        qBit      = ~remDiff[DWIDTH];
        remNew    = qBit ? remDiff[DWIDTH-1:0] : remSh[DWIDTH-1:0];
        accStep_d = op_q[2] ? {remNew, acc_q[DWIDTH-2:0], qBit}
                            : {mulSum, acc_q[DWIDTH-1:1]};

        prodAdj   = (signA_q ^ signB_q) ? -accStep_d : accStep_d;
        quot      = accStep_d[DWIDTH-1:0];
        rem       = accStep_d[2*DWIDTH-1:DWIDTH];
        bZero     = (opnd_q == {DWIDTH{1'b0}});
        result_d  = {DWIDTH{1'b0}};
        case (op_q)
            3'b000:                 result_d = prodAdj[DWIDTH-1:0];
            3'b001, 3'b010, 3'b011: result_d = prodAdj[2*DWIDTH-1:DWIDTH];
            3'b100, 3'b101: begin
                if (bZero)      result_d = {DWIDTH{1'b1}};
                else if (ovf_q) result_d = aRaw_q;
                else            result_d = (signA_q ^ signB_q) ? -quot : quot;
            end
            default: begin
                if (bZero)      result_d = aRaw_q;
                else if (ovf_q) result_d = {DWIDTH{1'b0}};
                else            result_d = signA_q ? -rem : rem;
            end
        endcase
    end

    // Flush only steers the control state; the datapath and the last result are left alone.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q <= IDLE;
            op_q    <= 3'b000;
            acc_q   <= {(2*DWIDTH){1'b0}};
            opnd_q  <= {DWIDTH{1'b0}};
            aRaw_q  <= {DWIDTH{1'b0}};
            signA_q <= 1'b0;
            signB_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= {DWIDTH{1'b0}};
            zero_q  <= 1'b1;
        end else if (md.MD_Flush) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    valid_q <= 1'b0;
                    if (md.MD_Start) begin
                        state_q <= CALC;
                        op_q    <= md.MD_OP;
                        acc_q   <= accLoad_d;
                        opnd_q  <= opndLoad_d;
                        aRaw_q  <= md.MD_In_A;
                        signA_q <= inSignA;
                        signB_q <= inSignB;
                        ovf_q   <= ovfLoad_d;
                        cnt_q   <= CW'(DWIDTH);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                CALC: begin
                    acc_q <= accStep_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b1;
                        out_q   <= result_d;
                        zero_q  <= (result_d == {DWIDTH{1'b0}});
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md.MD_Ready     = ready_q;
    assign md.MD_Busy      = busy_q;
    assign md.MD_Valid     = valid_q;
    assign md.MD_Out       = out_q;
    assign md.MD_Zero_Flag = zero_q;
endmodule
